// File: rtl/shr_carry_pkg.sv
// -----------------------------------------------------------------------------
// shr_carry_pkg
// Shared definitions for the sequential signed right shifter (shr_carry_seq).
//   SHAMT_W     : width of the shift-amount operand (0..31).
//   N_STAGES    : number of log2 shift stages, one per rshift bit.
//   shr_state_t : controller states.
// -----------------------------------------------------------------------------
package shr_carry_pkg;

  localparam int SHAMT_W  = 5;
  localparam int N_STAGES = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESID,
    DONE
  } shr_state_t;

endpackage

// File: rtl/shr_stage_sar.sv
// -----------------------------------------------------------------------------
// shr_stage_sar
// Combinational conditional arithmetic right shift by 2^k. When the stage
// amount reaches or exceeds the operand width the result saturates to all
// sign bits.
// Ports:
//   acc_i : operand (signed, W bits)
//   k_i   : stage index, shift amount is 2^k_i
//   en_i  : apply the shift (the matching rshift bit)
//   acc_o : shifted (or passed-through) operand
// -----------------------------------------------------------------------------
module shr_stage_sar
  import shr_carry_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]                acc_i,
  input  logic [$clog2(N_STAGES)-1:0] k_i,
  input  logic                        en_i,
  output logic [W-1:0]                acc_o
);

  logic [5:0] amt;

  always_comb begin
    amt   = 6'd1 << k_i;
    acc_o = acc_i;
    if (en_i) begin
      if (int'(amt) >= W) acc_o = {W{acc_i[W-1]}};
      else                acc_o = $signed(acc_i) >>> amt;
    end
  end

endmodule

// File: rtl/shr_carry_seq.sv
// -----------------------------------------------------------------------------
// shr_carry_seq
// Sequential signed arithmetic right shifter splitting a limb into a carry
// (q_out = s >>> rshift) and a residual (r_out = s - (q_out << rshift)).
// The shift runs in five log2 stages, one per cycle, followed by one cycle
// that forms the residual. Capture at edge T gives out_valid after edge T+6.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake for s and rshift
//   s, rshift           : signed operand, shift amount 0..31
//   out_valid/out_ready : output handshake; q_out and r_out held until accepted
//   q_out, r_out        : quotient (carry) and residual
//
// Handshake: a transfer happens on any rising edge where valid && ready.
// out_valid, once high, stays high with stable data until out_ready is seen.
// in_ready is high in IDLE, and in DONE only while out_ready is high, so a new
// operand can be taken on the same edge the previous result is accepted.
//
// Build option SHR_CARRY_ROUND_EN: round-to-nearest carry. The accumulator is
// widened by one bit and s + 2^(rshift-1) is loaded before shifting.
// -----------------------------------------------------------------------------
module shr_carry_seq
  import shr_carry_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   s,
  input  logic [SHAMT_W-1:0] rshift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   q_out,
  output logic [WIDTH-1:0]   r_out
);

  localparam int K_W = $clog2(N_STAGES);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_STAGES - 1);

`ifdef SHR_CARRY_ROUND_EN
  localparam int ACC_W = WIDTH + 1;
  localparam logic [SHAMT_W:0] WIDTH_SH = (SHAMT_W + 1)'(WIDTH);
`else
  localparam int ACC_W = WIDTH;
`endif

  shr_state_t         state_q;
  logic [K_W-1:0]     k_q;
  logic [ACC_W-1:0]   acc_q;
  logic [WIDTH-1:0]   s_q;
  logic [SHAMT_W-1:0] rshift_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   r_q;
  logic               out_valid_q;
  // Low during reset and set on the first edge after release, so in_ready
  // stays low while rst_n is asserted even though the state reads IDLE.
  logic               live_q;

  logic [ACC_W-1:0]   acc_cap_d;
  logic [ACC_W-1:0]   acc_shift_d;
  logic [WIDTH-1:0]   resid_d;
  logic               accept;

  assign in_ready  = live_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign q_out     = q_q;
  assign r_out     = r_q;

  // Value loaded into the accumulator on capture.
  always_comb begin
`ifdef SHR_CARRY_ROUND_EN
    acc_cap_d = {s[WIDTH-1], s};
    // For rshift >= WIDTH the rounded quotient is zero for every s; the
    // rounding term would not fit the accumulator, so load zero directly.
    if ({1'b0, rshift} >= WIDTH_SH) acc_cap_d = '0;
    else if (rshift != '0)          acc_cap_d = {s[WIDTH-1], s} + (ACC_W'(1) << (rshift - 1'b1));
`else
    acc_cap_d = s;
`endif
  end

  shr_stage_sar #(.W(ACC_W)) u_stage (
    .acc_i (acc_q),
    .k_i   (k_q),
    .en_i  (rshift_q[k_q]),
    .acc_o (acc_shift_d)
  );

  // Quotient fits WIDTH bits in both modes; a shift of WIDTH or more makes
  // the subtracted term zero, leaving r_out = s.
  assign resid_d = s_q - (acc_q[WIDTH-1:0] << rshift_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      rshift_q    <= '0;
      q_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            s_q      <= s;
            rshift_q <= rshift;
            acc_q    <= acc_cap_d;
            k_q      <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_shift_d;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= RESID;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        RESID: begin
          q_q         <= acc_q[WIDTH-1:0];
          r_q         <= resid_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              s_q      <= s;
              rshift_q <= rshift;
              acc_q    <= acc_cap_d;
              k_q      <= '0;
              state_q  <= SHIFT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shr_carry_seq.sv
// -----------------------------------------------------------------------------
// tb_shr_carry_seq
// Directed bench for shr_carry_seq. Two instances (WIDTH=32 and WIDTH=8) share
// the input stimulus; each step checks the instance it targets. Expected
// values are hand-computed for both the floor build and the
// SHR_CARRY_ROUND_EN build.
// -----------------------------------------------------------------------------
module tb_shr_carry_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] s_in = '0;
  logic [4:0]  sh_in = '0;

  logic        rdy32, ov32;
  logic [31:0] q32, r32;
  logic        rdy8, ov8;
  logic [7:0]  q8, r8;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  shr_carry_seq #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .s(s_in), .rshift(sh_in), .out_valid(ov32), .out_ready(out_ready),
    .q_out(q32), .r_out(r32)
  );

  shr_carry_seq #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .s(s_in[7:0]), .rshift(sh_in), .out_valid(ov8), .out_ready(out_ready),
    .q_out(q8), .r_out(r8)
  );

  // ---------------- helpers ----------------
  function automatic logic [31:0] pick(input logic [31:0] floor_v, input logic [31:0] round_v);
`ifdef SHR_CARRY_ROUND_EN
    return round_v;
`else
    return floor_v;
`endif
  endfunction

  function automatic logic [31:0] q_of(input bit w8);
    return w8 ? {24'd0, q8} : q32;
  endfunction
  function automatic logic [31:0] r_of(input bit w8);
    return w8 ? {24'd0, r8} : r32;
  endfunction
  function automatic logic ov_of(input bit w8);
    return w8 ? ov8 : ov32;
  endfunction
  function automatic logic rdy_of(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 right after capture; waits (bounded) for out_valid
  // and checks that it appears after exactly six edges.
  task automatic wait_valid(input bit w8, input string tag);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ov_of(w8)) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'd6);
  endtask

  // One full transaction; entered and left at posedge+1 with the DUT idle.
  task automatic xact(input bit w8, input logic [31:0] sv, input logic [4:0] sh,
                      input logic [31:0] eq, input logic [31:0] er, input string tag);
    in_valid = 1'b1; s_in = sv; sh_in = sh; out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(rdy_of(w8)), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(w8, tag);
    check({tag, "_q"}, q_of(w8), eq);
    check({tag, "_r"}, r_of(w8), er);
    @(posedge clk); #1;
    check({tag, "_ovdrop"}, 32'(ov_of(w8)), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #12;
    check("rst_rdy32", 32'(rdy32), 32'd0);
    check("rst_rdy8",  32'(rdy8),  32'd0);
    check("rst_ov32",  32'(ov32),  32'd0);
    check("rst_q32",   q32, 32'd0);
    check("rst_r32",   r32, 32'd0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_rdy32", 32'(rdy32), 32'd1);
    check("rel_rdy8",  32'(rdy8),  32'd1);

    // Basic vectors, WIDTH=32
    xact(1'b0, 32'hFFFF_FF9C, 5'd3,  pick(32'hFFFF_FFF3, 32'hFFFF_FFF4), pick(32'd4, 32'hFFFF_FFFC), "neg100_sh3");
    xact(1'b0, 32'h7FFF_FFFF, 5'd31, pick(32'd0, 32'd1), pick(32'h7FFF_FFFF, 32'hFFFF_FFFF), "maxpos_sh31");
    xact(1'b0, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32'd0, "minneg_sh31");
    xact(1'b0, 32'd1000,      5'd4,  pick(32'd62, 32'd63), pick(32'd8, 32'hFFFF_FFF8), "p1000_sh4");
    xact(1'b0, 32'hFFFF_FFFF, 5'd1,  pick(32'hFFFF_FFFF, 32'd0), pick(32'd1, 32'hFFFF_FFFF), "m1_sh1");
    xact(1'b0, 32'h1234_5678, 5'd16, 32'h0000_1234, 32'h0000_5678, "hex_sh16");
    xact(1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 32'd0, "sh0_w32");

    // WIDTH=8 vectors
    xact(1'b1, 32'h0000_00FF, 5'd20, pick(32'h0000_00FF, 32'd0), 32'h0000_00FF, "w8_m1_sh20");
    xact(1'b1, 32'h0000_0055, 5'd0,  32'h0000_0055, 32'd0, "w8_55_sh0");
    xact(1'b1, 32'h0000_0080, 5'd8,  pick(32'h0000_00FF, 32'd0), 32'h0000_0080, "w8_min_sh8");
    xact(1'b1, 32'h0000_007F, 5'd3,  pick(32'h0000_000F, 32'h0000_0010), pick(32'd7, 32'h0000_00FF), "w8_7f_sh3");

    // Backpressure: result held for 10 cycles, then same-edge accept
    in_valid = 1'b1; s_in = 32'hFFFF_FF9C; sh_in = 5'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov",  32'(ov32),  32'd1);
      check("bp_hold_q",   q32, pick(32'hFFFF_FFF3, 32'hFFFF_FFF4));
      check("bp_hold_r",   r32, pick(32'd4, 32'hFFFF_FFFC));
      check("bp_hold_rdy", 32'(rdy32), 32'd0);
    end
    in_valid = 1'b1; s_in = 32'd64; sh_in = 5'd2; out_ready = 1'b1;
    #1 check("bp_rdy_with_oready", 32'(rdy32), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_ov_after_hs", 32'(ov32), 32'd0);
    check("bp_rdy_shift",   32'(rdy32), 32'd0);
    wait_valid(1'b0, "bp_next");
    check("bp_next_q", q32, 32'd16);
    check("bp_next_r", r32, 32'd0);
    @(posedge clk); #1;
    check("bp_next_ovdrop", 32'(ov32), 32'd0);

    // Reset in the middle of SHIFT (k=2)
    in_valid = 1'b1; s_in = 32'd1000; sh_in = 5'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov32",  32'(ov32),  32'd0);
    check("mid_rst_ov8",   32'(ov8),   32'd0);
    check("mid_rst_rdy32", 32'(rdy32), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_rdy32", 32'(rdy32), 32'd1);
    check("mid_rel_rdy8",  32'(rdy8),  32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mid_no_stale", 32'(ov32 | ov8), 32'd0);
    end

    // Recovery after reset
    xact(1'b0, 32'd64, 5'd2, 32'd16, 32'd0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
